display_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller that shares one BCD-to-7-segment decoder
//   (4-bit input e, active-low abcdefg output) between N_DIGITS common-anode digits.

---
 rtl/display_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Scan controller for N_DIGITS common-anode 7-segment digits that share one
//   BCD decoder. It holds the displayed word, accepts a new word through a
//   ready/valid handshake and swaps it in at the next frame boundary. It adds a
//   dark guard band between digit slots and can suppress leading zeros.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   en           1 = scan running, 0 = display dark
//   load         valid for digits_in
//   digits_in    BCD word, digit0 = [3:0] (rightmost)
//   lz_en        1 = blank leading zeros
//   ready        1 = load accepted this cycle
//   load_ack     1-cycle pulse when the pending word reaches the display
//   bcd_out      decoder input, 4'hF = blank
//   digit_sel_n  active-low anode enables, one-hot-low while driving
//
// state | meaning
// IDLE  | scan stopped, all anodes off
// DRIVE | anode idx on, bcd_out shows digit idx for PRESCALE cycles
// GUARD | all anodes off for GUARD_CYC cycles before the next digit
module display_scan_ctrl #(
   parameter int N_DIGITS  = 4,
   parameter int PRESCALE  = 50000,
   parameter int GUARD_CYC = 500
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] digits_in,
   input  logic                  lz_en,
   output logic                  ready,
   output logic                  load_ack,
   output logic [3:0]            bcd_out,
   output logic [N_DIGITS-1:0]   digit_sel_n
);

   localparam int CMAX = (PRESCALE > GUARD_CYC) ? PRESCALE : GUARD_CYC;
   localparam int CW   = $clog2(CMAX);
   localparam int IW   = $clog2(N_DIGITS);
   localparam logic [CW-1:0] P_LAST = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] G_LAST = (GUARD_CYC > 0) ? CW'(GUARD_CYC - 1) : '0;
   localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, GUARD} state_t;

   state_t                state, state_n;
   logic [IW-1:0]         idx, idx_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [4*N_DIGITS-1:0] active, active_n;
   logic [4*N_DIGITS-1:0] pending, pending_n;
   logic                  pend_v, pend_v_n;
   logic                  frame_start;
   logic                  ack_n;
   logic [3:0]            bcd_n;
   logic [N_DIGITS-1:0]   sel_n;
   logic                  lz_all;

   assign ready = ~pend_v;

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      cnt_n       = cnt;
      active_n    = active;
      pending_n   = pending;
      pend_v_n    = pend_v;
      frame_start = 1'b0;
      ack_n       = 1'b0;
      bcd_n       = 4'hF;
      sel_n       = '1;
      lz_all      = 1'b1;

      case (state)
         IDLE: begin
            if (en) begin
               state_n     = DRIVE;
               idx_n       = '0;
               cnt_n       = '0;
               frame_start = 1'b1;
            end
         end
         DRIVE: begin
            if (cnt == P_LAST) begin
               cnt_n = '0;
               if (GUARD_CYC > 0) begin
                  state_n = GUARD;
               end else begin
                  idx_n       = (idx == I_LAST) ? '0 : idx + 1'b1;
                  frame_start = (idx == I_LAST);
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         GUARD: begin
            if (cnt == G_LAST) begin
               cnt_n       = '0;
               state_n     = DRIVE;
               idx_n       = (idx == I_LAST) ? '0 : idx + 1'b1;
               frame_start = (idx == I_LAST);
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      if (!en) begin
         state_n     = IDLE;
         idx_n       = '0;
         cnt_n       = '0;
         frame_start = 1'b0;
      end

      // Capture and transfer are exclusive: capture needs pend_v=0, transfer pend_v=1.
      if (load && !pend_v) begin
         pending_n = digits_in;
         pend_v_n  = 1'b1;
      end
      if (frame_start && pend_v) begin
         active_n = pending;
         pend_v_n = 1'b0;
         ack_n    = 1'b1;
      end

      // Outputs are computed from next-state values so they register on the same edge.
      if (state_n == DRIVE) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            if (IW'(i) >= idx_n && active_n[4*i +: 4] != 4'h0) lz_all = 1'b0;
            if (IW'(i) == idx_n) begin
               sel_n[i] = 1'b0;
               bcd_n    = active_n[4*i +: 4];
            end
         end
         // Anode stays on when blanked so every digit keeps the same duty cycle.
         if (lz_en && lz_all && idx_n != '0) bcd_n = 4'hF;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         cnt         <= '0;
         active      <= '0;
         pending     <= '0;
         pend_v      <= 1'b0;
         load_ack    <= 1'b0;
         bcd_out     <= 4'hF;
         digit_sel_n <= '1;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         cnt         <= cnt_n;
         active      <= active_n;
         pending     <= pending_n;
         pend_v      <= pend_v_n;
         load_ack    <= ack_n;
         bcd_out     <= bcd_n;
         digit_sel_n <= sel_n;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
//   Directed bench for display_scan_ctrl with N_DIGITS=4, PRESCALE=4,
//   GUARD_CYC=1 (frame period 20 cycles).
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        load;
   logic [15:0] digits_in;
   logic        lz_en;
   logic        ready;
   logic        load_ack;
   logic [3:0]  bcd_out;
   logic [3:0]  digit_sel_n;

   int tests = 0;
   int fails = 0;

   display_scan_ctrl #(
      .N_DIGITS (4),
      .PRESCALE (4),
      .GUARD_CYC(1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .load       (load),
      .digits_in  (digits_in),
      .lz_en      (lz_en),
      .ready      (ready),
      .load_ack   (load_ack),
      .bcd_out    (bcd_out),
      .digit_sel_n(digit_sel_n)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [15:0] word);
      load      = 1'b1;
      digits_in = word;
      tick();
      load      = 1'b0;
   endtask

   // Advance until load_ack is seen, bounded so a missing ack cannot hang the run.
   task automatic wait_boundary();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!load_ack && n < 60);
      chk("ack_seen", {31'd0, load_ack}, 32'd1);
   endtask

   // Called at the first cycle of a frame; returns at the first cycle of the next one.
   task automatic check_frame(input logic [15:0] exp);
      logic [3:0] es;
      for (int d = 0; d < 4; d++) begin
         es = ~(4'b0001 << d);
         for (int c = 0; c < 4; c++) begin
            chk($sformatf("sel_d%0d_c%0d", d, c), {28'd0, digit_sel_n}, {28'd0, es});
            chk($sformatf("bcd_d%0d_c%0d", d, c), {28'd0, bcd_out}, {28'd0, exp[4*d +: 4]});
            tick();
         end
         chk($sformatf("guard_sel_d%0d", d), {28'd0, digit_sel_n}, 32'hF);
         chk($sformatf("guard_bcd_d%0d", d), {28'd0, bcd_out}, 32'hF);
         tick();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      load      = 1'b0;
      digits_in = 16'h0;
      lz_en     = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst_sel",   {28'd0, digit_sel_n}, 32'hF);
      chk("rst_bcd",   {28'd0, bcd_out}, 32'hF);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_ack",   {31'd0, load_ack}, 32'd0);
      rst_n = 1'b1;

      // basic scan of 1234
      do_load(16'h1234);
      chk("ready_after_load", {31'd0, ready}, 32'd0);
      en = 1'b1;
      tick();
      chk("first_ack", {31'd0, load_ack}, 32'd1);
      chk("first_ready", {31'd0, ready}, 32'd1);
      check_frame(16'h1234);
      chk("period_sel", {28'd0, digit_sel_n}, 32'hE);
      chk("no_second_ack", {31'd0, load_ack}, 32'd0);

      // leading-zero suppression
      lz_en = 1'b1;
      do_load(16'h0042);
      wait_boundary();
      check_frame(16'hFF42);
      do_load(16'h0000);
      wait_boundary();
      check_frame(16'hFFF0);
      lz_en = 1'b0;
      do_load(16'h0042);
      wait_boundary();
      check_frame(16'h0042);

      // mid-frame load, second load while busy is dropped
      for (int i = 0; i < 6; i++) tick();
      do_load(16'h5678);
      chk("busy_ready", {31'd0, ready}, 32'd0);
      do_load(16'h9999);
      chk("busy_ready2", {31'd0, ready}, 32'd0);
      wait_boundary();
      chk("ready_back", {31'd0, ready}, 32'd1);
      check_frame(16'h5678);

      // reset during guard of digit 2 loses the pending word
      do_load(16'h7777);
      for (int i = 0; i < 13; i++) tick();
      chk("g2_sel",   {28'd0, digit_sel_n}, 32'hF);
      chk("g2_bcd",   {28'd0, bcd_out}, 32'hF);
      chk("g2_ready", {31'd0, ready}, 32'd0);
      rst_n = 1'b0;
      tick();
      chk("mrst_sel",   {28'd0, digit_sel_n}, 32'hF);
      chk("mrst_bcd",   {28'd0, bcd_out}, 32'hF);
      chk("mrst_ready", {31'd0, ready}, 32'd1);
      chk("mrst_ack",   {31'd0, load_ack}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("restart_sel", {28'd0, digit_sel_n}, 32'hE);
      chk("restart_bcd", {28'd0, bcd_out}, 32'h0);
      chk("restart_ack", {31'd0, load_ack}, 32'd0);
      do_load(16'h0001);
      wait_boundary();
      check_frame(16'h0001);

      // non-BCD values pass through; en toggle
      do_load(16'hABCF);
      wait_boundary();
      check_frame(16'hABCF);
      en = 1'b0;
      tick();
      chk("off_sel", {28'd0, digit_sel_n}, 32'hF);
      chk("off_bcd", {28'd0, bcd_out}, 32'hF);
      tick();
      chk("off_sel2", {28'd0, digit_sel_n}, 32'hF);
      en = 1'b1;
      tick();
      chk("reen_sel", {28'd0, digit_sel_n}, 32'hE);
      chk("reen_bcd", {28'd0, bcd_out}, 32'hF);
      chk("reen_ack", {31'd0, load_ack}, 32'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("reen_d1_sel", {28'd0, digit_sel_n}, 32'hD);
      chk("reen_d1_bcd", {28'd0, bcd_out}, 32'hC);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
